// File: rtl/wb_serial_bridge.sv
// -----------------------------------------------------------------------------
// wb_serial_bridge
//
// Host debug/loader port: turns a UART byte stream into single Wishbone
// classic cycles and returns status/data bytes to a UART transmitter.
//
// Packets:
//   'W' (0x57) addr[31:0] data[31:0]  -> write, reply 0x06
//   'R' (0x52) addr[31:0]             -> read, reply 4 data bytes MSB first
//   anything else                     -> reply 0x15
//   Bus timeout (no ack)              -> reply 0x15
//
// Optional feature (macro WB_SERIAL_BRIDGE_AUTOINC_EN):
//   Address persists and advances by 4 after each acked cycle; adds
//   'w' (0x77) data[31:0] and 'r' (0x72) commands using the stored address.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous reset, active-low
//   wb_adr_o    Wishbone address (word aligned)
//   wb_dat_o    Wishbone write data
//   wb_dat_i    Wishbone read data
//   wb_sel_o    byte selects (all ones during a cycle)
//   wb_we_o     write enable
//   wb_cyc_o    cycle
//   wb_stb_o    strobe
//   wb_ack_i    acknowledge
//   rx_data_i   received byte
//   rx_valid_i  one-cycle strobe for rx_data_i
//   tx_data_o   byte to transmit
//   tx_valid_o  tx_data_o valid, held until accepted
//   tx_ready_i  transmitter accepts when tx_valid_o & tx_ready_i
//   overrun_o   one-cycle pulse when an rx byte is dropped
// -----------------------------------------------------------------------------
module wb_serial_bridge #(
    parameter int unsigned TIMEOUT     = 2000000,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        overrun_o
);

    localparam logic [31:0] TMO_LIM = 32'(TIMEOUT);
    localparam logic [31:0] BTO_LIM = 32'(BUS_TIMEOUT);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK_B = 8'h06;
    localparam logic [7:0] NAK_B = 8'h15;
`ifdef WB_SERIAL_BRIDGE_AUTOINC_EN
    localparam logic [7:0] CMD_WI = 8'h77;
    localparam logic [7:0] CMD_RI = 8'h72;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;        // bytes already received in ADDR/DATA
    logic        is_wr_q, is_wr_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;      // remaining read bytes, next one in [31:24]
    logic [1:0]  left_q, left_d;      // reply bytes still to send after current
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] tmo_q, tmo_d;        // idle cycles since last accepted byte
    logic [31:0] bto_q, bto_d;        // cycles spent waiting for ack
    logic        ovr_q, ovr_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            is_wr_q    <= 1'b0;
            adr_q      <= 32'd0;
            wdat_q     <= 32'd0;
            rdat_q     <= 32'd0;
            left_q     <= 2'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            tmo_q      <= 32'd0;
            bto_q      <= 32'd0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            left_q     <= left_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tmo_q      <= tmo_d;
            bto_q      <= bto_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        left_d     = left_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tmo_d      = tmo_q;
        bto_d      = bto_q;
        ovr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = 32'd0;
                cnt_d = 2'd0;
                if (rx_valid_i) begin
                    case (rx_data_i)
                        CMD_W: begin
                            is_wr_d = 1'b1;
                            state_d = S_ADDR;
                        end
                        CMD_R: begin
                            is_wr_d = 1'b0;
                            state_d = S_ADDR;
                        end
`ifdef WB_SERIAL_BRIDGE_AUTOINC_EN
                        CMD_WI: begin
                            is_wr_d = 1'b1;
                            state_d = S_DATA;
                        end
                        CMD_RI: begin
                            is_wr_d = 1'b0;
                            bto_d   = 32'd0;
                            state_d = S_BUS;
                        end
`endif
                        default: begin
                            tx_data_d  = NAK_B;
                            tx_valid_d = 1'b1;
                            left_d     = 2'd0;
                            state_d    = S_RESP;
                        end
                    endcase
                end
            end

            S_ADDR, S_DATA: begin
                if (rx_valid_i) begin
                    tmo_d = 32'd0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == S_ADDR) begin
                        adr_d = {adr_q[23:0], rx_data_i};
                    end else begin
                        wdat_d = {wdat_q[23:0], rx_data_i};
                    end
                    if (cnt_q == 2'd3) begin
                        if (state_q == S_ADDR && is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            bto_d   = 32'd0;
                            state_d = S_BUS;
                        end
                    end
                end else if (TMO_LIM != 32'd0) begin
                    // Partial packet abandoned silently after TIMEOUT idle cycles.
                    if (tmo_q >= TMO_LIM - 32'd1) begin
                        tmo_d   = 32'd0;
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end

            S_BUS: begin
                ovr_d = rx_valid_i;
                if (wb_ack_i) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                    if (is_wr_q) begin
                        tx_data_d = ACK_B;
                        left_d    = 2'd0;
                    end else begin
                        tx_data_d = wb_dat_i[31:24];
                        rdat_d    = {wb_dat_i[23:0], 8'h00};
                        left_d    = 2'd3;
                    end
`ifdef WB_SERIAL_BRIDGE_AUTOINC_EN
                    adr_d = {adr_q[31:2] + 30'd1, 2'b00};
`endif
                end else if (BTO_LIM != 32'd0 && bto_q >= BTO_LIM - 32'd1) begin
                    tx_data_d  = NAK_B;
                    tx_valid_d = 1'b1;
                    left_d     = 2'd0;
                    state_d    = S_RESP;
                end else begin
                    bto_d = bto_q + 32'd1;
                end
            end

            S_RESP: begin
                ovr_d = rx_valid_i;
                if (tx_valid_q && tx_ready_i) begin
                    if (left_q != 2'd0) begin
                        tx_data_d = rdat_q[31:24];
                        rdat_d    = {rdat_q[23:0], 8'h00};
                        left_d    = left_q - 2'd1;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes derive from the state register so an async reset drops
    // them immediately.
    assign wb_cyc_o   = (state_q == S_BUS);
    assign wb_stb_o   = wb_cyc_o;
    assign wb_we_o    = wb_cyc_o & is_wr_q;
    assign wb_sel_o   = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_adr_o   = {adr_q[31:2], 2'b00};
    assign wb_dat_o   = wdat_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_wb_serial_bridge.sv
module tb_wb_serial_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    wb_serial_bridge #(
        .TIMEOUT    (100),
        .BUS_TIMEOUT(255)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .wb_adr_o  (wb_adr),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel),
        .wb_we_o   (wb_we),
        .wb_cyc_o  (wb_cyc),
        .wb_stb_o  (wb_stb),
        .wb_ack_i  (wb_ack),
        .rx_data_i (rx_data),
        .rx_valid_i(rx_valid),
        .tx_data_o (tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; strobes one byte across the next edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Receives one byte with tx_ready toggled randomly; checks the byte
    // stays stable while waiting and matches the expected value.
    task automatic recv(input string tag, input logic [7:0] exp);
        logic [7:0] first;
        logic [7:0] got;
        bit seen;
        bit done;
        seen = 0;
        done = 0;
        first = 8'd0;
        got = 8'd0;
        for (int i = 0; i < 60 && !done; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (i == 59) tx_ready = 1'b1;
            if (tx_valid === 1'b1) begin
                if (!seen) begin first = tx_data; seen = 1; end
                if (tx_ready) begin got = tx_data; done = 1; end
            end
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
        chk({tag, "_handshake"}, 32'(done), 32'd1);
        chk({tag, "_stable"}, 32'(got), 32'(first));
        chk(tag, 32'(got), 32'(exp));
    endtask

    int  n;
    bit  ovr_hit;
    bit  ovr_after;
    bit  cyc_seen;
    bit  tx_seen;

    initial begin
        // Reset values
        tick(2);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", 32'(wb_sel), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Write 0xDEADBEEF to 0x4000, ack after 3 cycles
        send_byte(8'h57);
        send4(32'h0000_4000);
        send4(32'hDEAD_BEEF);
        chk("w_cyc", 32'(wb_cyc), 32'd1);
        chk("w_stb", 32'(wb_stb), 32'd1);
        chk("w_adr", wb_adr, 32'h0000_4000);
        chk("w_we", 32'(wb_we), 32'd1);
        chk("w_dat", wb_dat_o, 32'hDEAD_BEEF);
        chk("w_sel", 32'(wb_sel), 32'hF);
        tick(2);
        chk("w_cyc_wait", 32'(wb_cyc), 32'd1);
        chk("w_txv_wait", 32'(tx_valid), 32'd0);
        wb_ack = 1'b1;
        tick(1);
        wb_ack = 1'b0;
        chk("w_cyc_drop", 32'(wb_cyc), 32'd0);
        chk("w_txv", 32'(tx_valid), 32'd1);
        recv("w_reply", 8'h06);
        chk("w_txv_end", 32'(tx_valid), 32'd0);

        // Read 0x4000, zero-wait slave returning 0x12345678
        send_byte(8'h52);
        send4(32'h0000_4000);
        chk("r_cyc", 32'(wb_cyc), 32'd1);
        chk("r_we", 32'(wb_we), 32'd0);
        chk("r_adr", wb_adr, 32'h0000_4000);
        wb_ack = 1'b1;
        wb_dat_i = 32'h1234_5678;
        tick(1);
        wb_ack = 1'b0;
        wb_dat_i = 32'd0;
        chk("r_cyc_drop", 32'(wb_cyc), 32'd0);
        recv("r_b0", 8'h12);
        recv("r_b1", 8'h34);
        recv("r_b2", 8'h56);
        recv("r_b3", 8'h78);
        tick(3);
        chk("r_txv_end", 32'(tx_valid), 32'd0);

        // Unknown command byte
        send_byte(8'h41);
        chk("unk_txv", 32'(tx_valid), 32'd1);
        chk("unk_cyc", 32'(wb_cyc), 32'd0);
        recv("unk_reply", 8'h15);

        // Following read works; low address bits are forced to zero
        send_byte(8'h52);
        send4(32'h0000_0013);
        chk("al_adr", wb_adr, 32'h0000_0010);
        tick(1);
        wb_ack = 1'b1;
        wb_dat_i = 32'hA5A5_0F0F;
        tick(1);
        wb_ack = 1'b0;
        recv("al_b0", 8'hA5);
        recv("al_b1", 8'hA5);
        recv("al_b2", 8'h0F);
        recv("al_b3", 8'h0F);

`ifndef WB_SERIAL_BRIDGE_AUTOINC_EN
        // Without auto-increment 'w' is just an unknown byte
        send_byte(8'h77);
        chk("w_unk_txv", 32'(tx_valid), 32'd1);
        recv("w_unk_reply", 8'h15);
`endif

        // Bus timeout on a read, with an rx byte dropped during the wait
        send_byte(8'h52);
        send4(32'h0000_0020);
        n = 0;
        ovr_hit = 0;
        ovr_after = 1;
        while (wb_cyc === 1'b1 && n < 400) begin
            if (n == 10) begin rx_data = 8'h55; rx_valid = 1'b1; end
            @(posedge clk); #1;
            rx_valid = 1'b0;
            n++;
            if (n == 11) ovr_hit = overrun;
            if (n == 12) ovr_after = overrun;
        end
        chk("bto_cycles", 32'(n), 32'd255);
        chk("bto_ovr_pulse", 32'(ovr_hit), 32'd1);
        chk("bto_ovr_one", 32'(ovr_after), 32'd0);
        chk("bto_txv", 32'(tx_valid), 32'd1);
        recv("bto_reply", 8'h15);
        tick(2);
        chk("bto_txv_end", 32'(tx_valid), 32'd0);

        // Partial write abandoned after inter-byte timeout
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        cyc_seen = 0;
        tx_seen = 0;
        for (int i = 0; i < 150; i++) begin
            if (wb_cyc === 1'b1) cyc_seen = 1;
            if (tx_valid === 1'b1) tx_seen = 1;
            tick(1);
        end
        chk("ibt_no_cyc", 32'(cyc_seen), 32'd0);
        chk("ibt_no_tx", 32'(tx_seen), 32'd0);
        send_byte(8'h52);
        send4(32'h0000_0040);
        chk("ibt_r_cyc", 32'(wb_cyc), 32'd1);
        chk("ibt_r_we", 32'(wb_we), 32'd0);
        chk("ibt_r_adr", wb_adr, 32'h0000_0040);
        tick(1);
        wb_ack = 1'b1;
        wb_dat_i = 32'hCAFE_F00D;
        tick(1);
        wb_ack = 1'b0;
        recv("ibt_b0", 8'hCA);
        recv("ibt_b1", 8'hFE);
        recv("ibt_b2", 8'hF0);
        recv("ibt_b3", 8'h0D);

        // Asynchronous reset during a bus cycle
        send_byte(8'h52);
        send4(32'h0000_0080);
        chk("ar_cyc_pre", 32'(wb_cyc), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cyc", 32'(wb_cyc), 32'd0);
        chk("ar_stb", 32'(wb_stb), 32'd0);
        chk("ar_adr", wb_adr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);
        chk("ar_txv", 32'(tx_valid), 32'd0);

`ifdef WB_SERIAL_BRIDGE_AUTOINC_EN
        // 'W' 0x100 data 1, then 'w' data 2, then 'r'
        send_byte(8'h57);
        send4(32'h0000_0100);
        send4(32'h0000_0001);
        chk("ai_w_adr", wb_adr, 32'h0000_0100);
        chk("ai_w_dat", wb_dat_o, 32'h0000_0001);
        wb_ack = 1'b1;
        tick(1);
        wb_ack = 1'b0;
        recv("ai_w_reply", 8'h06);
        send_byte(8'h77);
        send4(32'h0000_0002);
        chk("ai_wi_cyc", 32'(wb_cyc), 32'd1);
        chk("ai_wi_adr", wb_adr, 32'h0000_0104);
        chk("ai_wi_we", 32'(wb_we), 32'd1);
        chk("ai_wi_dat", wb_dat_o, 32'h0000_0002);
        wb_ack = 1'b1;
        tick(1);
        wb_ack = 1'b0;
        recv("ai_wi_reply", 8'h06);
        send_byte(8'h72);
        chk("ai_ri_cyc", 32'(wb_cyc), 32'd1);
        chk("ai_ri_adr", wb_adr, 32'h0000_0108);
        chk("ai_ri_we", 32'(wb_we), 32'd0);
        wb_ack = 1'b1;
        wb_dat_i = 32'h0102_0304;
        tick(1);
        wb_ack = 1'b0;
        recv("ai_ri_b0", 8'h01);
        recv("ai_ri_b1", 8'h02);
        recv("ai_ri_b2", 8'h03);
        recv("ai_ri_b3", 8'h04);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_serial_bridge.md
# wb_serial_bridge

Wishbone bus master driven by a byte stream: decodes read/write command packets arriving from a UART receiver, runs single Wishbone cycles on the system data bus, and returns status/data bytes to a UART transmitter. Used as a host-side debug/loader port; sits beside the CPU data master on the MMU data bus and lets the host peek, poke and download memory without CPU involvement.

## Interface
- TIMEOUT, 2000000: idle cycles between received bytes before a partial packet is abandoned (0 disables)
- BUS_TIMEOUT, 255: cycles to wait for ack before the bus cycle is aborted
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-low
- bus  if_wb.master  -  adr 32, dat_o 32, dat_i 32, sel 4, we, cyc, stb out/in per Wishbone classic; ack in
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready at clock edge
- overrun  out  1  one-cycle pulse: rx byte dropped while not accepting

## Operation
- Packets: 0x57 'W' + addr[31:0] (4 bytes, MSB first) + data[31:0] (4 bytes, MSB first) → write, reply 0x06. 0x52 'R' + addr (4 bytes) → read, reply dat_i as 4 bytes MSB first.
- Any other first byte → reply 0x15, back to IDLE.
- States: IDLE → ADDR (count 4) → DATA (count 4, write only) → BUS → RESP (1 or 4 bytes) → IDLE.
- Bytes accepted only in IDLE/ADDR/DATA; rx_valid in BUS/RESP drops byte, pulses overrun.
- BUS: cyc=stb=1, sel=4'hF, we per command, adr/dat_o from shift registers; on ack: latch dat_i, drop cyc/stb same edge, go RESP.
- Bus timeout: BUS_TIMEOUT cycles without ack → drop cyc/stb, reply single 0x15 (also for reads), IDLE.
- Inter-byte timeout: in ADDR/DATA, TIMEOUT cycles with no rx_valid → IDLE silently, counters cleared.
- adr forced to word alignment: adr[1:0]=0 regardless of received bits.

## Timing
- Reset values: cyc=stb=we=0, adr=0, dat_o=0, sel=0, tx_valid=0, tx_data=0, overrun=0; state IDLE.
- Bus cycle starts cycle after last packet byte strobed; cyc/stb deassert on edge where ack sampled (no back-to-back).
- ack in same cycle as stb assertion is legal (zero-wait slave): cycle lasts 1 clock.
- tx_valid asserts cycle after bus completion; tx_data/tx_valid stable until tx_ready; next byte presented the cycle after acceptance.
- rx_valid and tx handshake in same cycle are independent.
- Reset mid-cycle: cyc/stb drop immediately (async), partial packet discarded.
- Timeout counters saturate; counter reloads on every accepted byte.

## Configuration
- WB_SERIAL_BRIDGE_AUTOINC_EN defined: address register persists after each completed command and increments by 4 (wraps 0xFFFFFFFC→0); extra commands 0x77 'w' + 4 data bytes (write at stored address, reply 0x06) and 0x72 'r' (read at stored address, 4 reply bytes). 'W'/'R' reload the stored address.
- Undefined: 0x77/0x72 are unknown bytes → reply 0x15; no address persistence logic.

## Test plan
- 'W' 0x00 0x00 0x40 0x00 0xDE 0xAD 0xBE 0xEF, slave ack after 3 cycles → one cycle adr=0x4000 we=1 dat_o=0xDEADBEEF sel=F, reply 0x06.
- 'R' 0x00 0x00 0x40 0x00, slave returns 0x12345678 → we=0, replies 0x12 0x34 0x56 0x78 in order, tx_ready toggled randomly, no byte lost/duplicated.
- Byte 0x41 in IDLE → reply 0x15, next valid 'R' works normally.
- 'R' to slave never acking, BUS_TIMEOUT=255 → cyc drops after 255 cycles, reply 0x15; rx byte during wait → overrun pulse.
- 'W' + 2 address bytes then silence, TIMEOUT=100 → no bus cycle, no reply; subsequent full 'R' completes; reset asserted during BUS → cyc=0 immediately.
- AUTOINC_EN: 'W' addr 0x100 data 1, then 'w' data 2, 'r' → writes at 0x100, 0x104, read at 0x108.
